// File: rtl/z80_mem_sched.sv
// z80_mem_sched: memory-access scheduler between the Z80 core, an optional
// DMA requester and the on-chip ROM/RAM wrappers.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   cpu_req/cpu_wr/cpu_addr  - CPU request, held until cpu_ack
//   cpu_wait_n, cpu_ack      - Z80 WAIT stall, one-cycle completion pulse
//   dma_req/dma_wr/dma_addr  - DMA request, held until dma_done
//   dma_gnt, dma_done        - DMA owns the path, one-cycle completion pulse
//   mem_addr                 - registered address to the slaves
//   rom_ena, ram_ena, ram_we - slave enables / RAM write enable
//
// Build option: define Z80_MEM_SCHED_DMA_EN to compile in round-robin
// CPU/DMA arbitration; otherwise the DMA inputs are ignored.

module z80_mem_sched #(
    parameter int unsigned ROM_SIZE = 'h8000,
    parameter int unsigned RAM_BASE = 'h8000,
    parameter int unsigned RAM_SIZE = 'h4000,
    parameter int unsigned ROM_WAIT = 1,
    parameter int unsigned RAM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    output logic        cpu_wait_n,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [15:0] dma_addr,
    output logic        dma_gnt,
    output logic        dma_done,
    output logic [15:0] mem_addr,
    output logic        rom_ena,
    output logic        ram_ena,
    output logic        ram_we
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // 17-bit bounds so a window ending at 'h10000 does not wrap
    localparam logic [16:0] ROM_END = 17'(ROM_SIZE);
    localparam logic [16:0] RAM_LO  = 17'(RAM_BASE);
    localparam logic [16:0] RAM_HI  = 17'(RAM_BASE + RAM_SIZE);
    localparam logic [3:0]  ROM_W   = 4'(ROM_WAIT);
    localparam logic [3:0]  RAM_W   = 4'(RAM_WAIT);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        own_dma;
    logic        wr_q;
    logic        sel_rom;
    logic        sel_ram;

    logic        win;
    logic        pick_dma;
    logic        win_wr;
    logic [15:0] win_addr;
    logic [16:0] win_a17;
    logic        hit_rom;
    logic        hit_ram;

`ifdef Z80_MEM_SCHED_DMA_EN
    logic last_dma;

    // On contention the side that did not win last time goes next
    assign win      = cpu_req || dma_req;
    assign pick_dma = dma_req && (!cpu_req || !last_dma);
    assign win_wr   = pick_dma ? dma_wr : cpu_wr;
    assign win_addr = pick_dma ? dma_addr : cpu_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dma <= 1'b1;
        end else if (state == IDLE && win) begin
            last_dma <= pick_dma;
        end
    end

    assign dma_gnt  = (state == ACCESS || state == DONE) && own_dma;
    assign dma_done = (state == DONE) && own_dma;
`else
    logic unused_dma;

    assign unused_dma = ^{dma_req, dma_wr, dma_addr};
    assign win        = cpu_req;
    assign pick_dma   = 1'b0;
    assign win_wr     = cpu_wr;
    assign win_addr   = cpu_addr;
    assign dma_gnt    = 1'b0;
    assign dma_done   = 1'b0;
`endif

    assign win_a17 = {1'b0, win_addr};
    assign hit_rom = win_a17 < ROM_END;
    assign hit_ram = !hit_rom && (win_a17 >= RAM_LO) && (win_a17 < RAM_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            own_dma  <= 1'b0;
            wr_q     <= 1'b0;
            sel_rom  <= 1'b0;
            sel_ram  <= 1'b0;
            mem_addr <= 16'h0000;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win) begin
                        mem_addr <= win_addr;
                        wr_q     <= win_wr;
                        own_dma  <= pick_dma;
                        sel_rom  <= hit_rom;
                        sel_ram  <= hit_ram;
                        if (hit_rom) begin
                            cnt   <= ROM_W;
                            state <= ACCESS;
                        end else if (hit_ram) begin
                            cnt   <= RAM_W;
                            state <= ACCESS;
                        end else begin
                            // unmapped: complete at once, no enable
                            cnt   <= 4'd0;
                            state <= DONE;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rom_ena    = (state == ACCESS) && sel_rom;
    assign ram_ena    = (state == ACCESS) && sel_ram;
    assign ram_we     = ram_ena && wr_q;
    assign cpu_ack    = (state == DONE) && !own_dma;
    assign cpu_wait_n = !(cpu_req && !cpu_ack);

endmodule
